// File: rtl/pipe_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_gen_pkg
//  Description : Shared types and constants for the pipe column generator.
//                ROWS      - number of rows in one display column
//                col_t     - one display column, bit 0 is the top row
//                state_t   - generator FSM states (GAP, PIPE)
//                LFSR_TAPS - feedback mask for x^8+x^6+x^5+x^4+1
//                pipe_column() - builds a lit column with a vertical opening
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_gen_pkg;

  localparam int ROWS = 16;

  typedef logic [ROWS-1:0] col_t;

  typedef enum logic {
    GAP  = 1'b0,
    PIPE = 1'b1
  } state_t;

  // Register bits 7,5,4,3 feed the XOR for a left-shifting Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Every row is lit except rows top .. top+g-1, which form the opening.
  function automatic col_t pipe_column(input logic [7:0] top, input logic [7:0] g);
    col_t c;
    for (int i = 0; i < ROWS; i++) begin
      c[i] = !((i >= int'(top)) && (i < int'(top) + int'(g)));
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr8
//  Description : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing on every
//                clock edge that is not a reset edge.
//  Ports       : Clock - rising-edge clock
//                RST   - synchronous active-high reset, loads seed
//                seed  - reset value (must be non-zero)
//                q     - current register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
  import pipe_gen_pkg::*;
(
  input  logic       Clock,
  input  logic       RST,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge Clock) begin
    if (RST) begin
      r_q <= seed;
    end else begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_gen
//  Description : Generates scrolling pipe columns for a 16-row display.
//                Emits SPACING empty columns, then PIPE_WIDTH identical pipe
//                columns with a pseudo-random opening, and repeats. Columns
//                advance only on ticks (slowdown & enable).
//  Ports       : Clock      - rising-edge clock
//                RST        - synchronous active-high reset
//                slowdown   - one-cycle column tick strobe
//                enable     - game running; 0 freezes generation
//                genPipes   - current column, 1 = lit cell, bit 0 = top row
//                new_pipe   - one-cycle pulse when a pipe starts
//                pipe_count - completed pipes since reset, saturates at 255
//  Config      : PIPE_GEN_DIFFICULTY_EN - when defined, the opening shrinks by
//                one row every 4 completed pipes down to 3 rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_gen
  import pipe_gen_pkg::*;
#(
  parameter int         PIPE_WIDTH = 2,
  parameter int         SPACING    = 4,
  parameter int         GAP_H      = 5,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
)(
  input  logic        Clock,
  input  logic        RST,
  input  logic        slowdown,
  input  logic        enable,
  output logic [15:0] genPipes,
  output logic        new_pipe,
  output logic [7:0]  pipe_count
);

  localparam logic [3:0] c_GAP_LAST  = 4'(SPACING - 1);
  localparam logic [3:0] c_PIPE_LAST = 4'(PIPE_WIDTH - 1);

  logic [7:0] w_lfsr;
  logic       w_tick;
  logic [7:0] w_g;
  logic [7:0] w_r;
  logic [7:0] w_top;
  col_t       w_pipe_col;

  state_t     r_state;
  logic [3:0] r_cnt;
  col_t       r_col;
  logic       r_new_pipe;
  logic [7:0] r_pipe_count;

  lfsr8 u_lfsr (
    .Clock (Clock),
    .RST   (RST),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  assign w_tick = slowdown & enable;

`ifdef PIPE_GEN_DIFFICULTY_EN
  localparam logic [7:0] c_MAX_SHRINK = 8'(GAP_H - 3);
  logic [7:0] w_level;
  assign w_level = r_pipe_count >> 2;
  assign w_g     = 8'(GAP_H) - ((w_level > c_MAX_SHRINK) ? c_MAX_SHRINK : w_level);
`else
  assign w_g = 8'(GAP_H);
`endif

  // Low nibble of the LFSR picks the opening; the +1 and the 15-G range keep
  // the opening clear of both the top and bottom rows.
  assign w_r        = w_lfsr & 8'h0F;
  assign w_top      = 8'd1 + (w_r % (8'd15 - w_g));
  assign w_pipe_col = pipe_column(w_top, w_g);

  always_ff @(posedge Clock) begin
    if (RST) begin
      r_state      <= GAP;
      r_cnt        <= 4'd0;
      r_col        <= '0;
      r_new_pipe   <= 1'b0;
      r_pipe_count <= 8'd0;
    end else begin
      r_new_pipe <= 1'b0;
      if (w_tick) begin
        case (r_state)
          GAP: begin
            if (r_cnt == c_GAP_LAST) begin
              r_state    <= PIPE;
              r_cnt      <= 4'd0;
              r_col      <= w_pipe_col;
              r_new_pipe <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
              r_col <= '0;
            end
          end
          PIPE: begin
            if (r_cnt == c_PIPE_LAST) begin
              r_state <= GAP;
              r_cnt   <= 4'd0;
              r_col   <= '0;
              if (r_pipe_count != 8'hFF) begin
                r_pipe_count <= r_pipe_count + 8'd1;
              end
            end else begin
              // Column is held so the pipe repeats unchanged.
              r_cnt <= r_cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

  assign genPipes   = r_col;
  assign new_pipe   = r_new_pipe;
  assign pipe_count = r_pipe_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_gen
//  Description : Scoreboard testbench for pipe_gen. The driver pushes the
//                expected outputs for every clock edge it issues; a monitor
//                pops and compares on the following falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_gen;

  localparam int         PW   = 2;
  localparam int         SP   = 4;
  localparam int         GH   = 5;
  localparam logic [7:0] SEED = 8'hA5;

  logic        Clock = 1'b0;
  logic        RST;
  logic        slowdown;
  logic        enable;
  logic [15:0] genPipes;
  logic        new_pipe;
  logic [7:0]  pipe_count;

  always #5 Clock = ~Clock;

  pipe_gen #(
    .PIPE_WIDTH (PW),
    .SPACING    (SP),
    .GAP_H      (GH),
    .LFSR_SEED  (SEED)
  ) dut (
    .Clock      (Clock),
    .RST        (RST),
    .slowdown   (slowdown),
    .enable     (enable),
    .genPipes   (genPipes),
    .new_pipe   (new_pipe),
    .pipe_count (pipe_count)
  );

  typedef struct {
    logic [15:0] col;
    logic        np;
    logic [7:0]  cnt;
    int          g;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [7:0]  m_lfsr = SEED;
  logic [15:0] e_col  = 16'h0;
  logic [7:0]  e_cnt  = 8'd0;
  logic [15:0] run1[$];
  int          replay_idx = 0;
  bit          recording  = 0;
  bit          replaying  = 0;

  // Expected column: all lit except a run of g zeros starting at row top.
  function automatic logic [15:0] gap_col(input logic [3:0] r, input int g);
    int          top;
    logic [15:0] ones;
    top  = 1 + (int'(r) % (15 - g));
    ones = (16'h1 << g) - 16'h1;
    return 16'hFFFF ^ (ones << top);
  endfunction

  function automatic int exp_g(input logic [7:0] cnt);
`ifdef PIPE_GEN_DIFFICULTY_EN
    int s;
    s = int'(cnt) / 4;
    if (s > GH - 3) s = GH - 3;
    return GH - s;
`else
    return GH + 0 * int'(cnt);
`endif
  endfunction

  // One clock edge: drive inputs at the falling edge, then after the rising
  // edge record what the outputs must be for the next cycle.
  task automatic step(input logic sd, input logic en, input logic rs,
                      input logic [15:0] col, input logic np,
                      input logic [7:0] cnt, input int g);
    exp_t e;
    @(negedge Clock);
    slowdown = sd;
    enable   = en;
    RST      = rs;
    @(posedge Clock);
    if (rs) m_lfsr = SEED;
    else     m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    e_col = col;
    e_cnt = cnt;
    e.col = col;
    e.np  = np;
    e.cnt = cnt;
    e.g   = g;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, e_col, 1'b0, e_cnt, 0);
  endtask

  task automatic freeze();
    step(1'b1, 1'b0, 1'b0, e_col, 1'b0, e_cnt, 0);
  endtask

  task automatic gap_tick();
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, e_cnt, 0);
    idle();
  endtask

  task automatic pipe_enter();
    int          g;
    logic [15:0] col;
    g   = exp_g(e_cnt);
    col = gap_col(m_lfsr[3:0], g);
    if (recording) run1.push_back(col);
    if (replaying) begin
      col = run1[replay_idx];
      replay_idx++;
    end
    step(1'b1, 1'b1, 1'b0, col, 1'b1, e_cnt, g);
  endtask

  task automatic pipe_repeat();
    step(1'b1, 1'b1, 1'b0, e_col, 1'b0, e_cnt, 0);
  endtask

  task automatic pipe_exit();
    logic [7:0] n;
    n = (e_cnt == 8'hFF) ? 8'hFF : 8'(e_cnt + 8'd1);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, n, 0);
  endtask

  // One full steady period: PIPE_WIDTH pipe ticks, exit tick, 3 more gaps.
  task automatic one_pipe();
    pipe_enter();
    idle();
    pipe_repeat();
    idle();
    pipe_exit();
    idle();
    repeat (3) gap_tick();
  endtask

  always @(negedge Clock) begin : mon
    exp_t e;
    int   zeros;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({genPipes, new_pipe, pipe_count} !== {e.col, e.np, e.cnt}) begin
        n_fail++;
        $display("FAIL outputs @%0t: got col=%h np=%b cnt=%0d, expected col=%h np=%b cnt=%0d",
                 $time, genPipes, new_pipe, pipe_count, e.col, e.np, e.cnt);
      end
      if (e.np) begin
        n_checks++;
        zeros = $countones(~genPipes);
        if (zeros != e.g || !genPipes[0] || !genPipes[15]) begin
          n_fail++;
          $display("FAIL gap_shape @%0t: got col=%h zeros=%0d, expected zeros=%0d with rows 0,15 lit",
                   $time, genPipes, zeros, e.g);
        end
      end
    end
  end

  initial begin
    RST      = 1'b1;
    slowdown = 1'b0;
    enable   = 1'b0;

    // Reset and lead-in: three ticks give empty columns only.
    step(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 8'd0, 0);
    step(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 8'd0, 0);
    idle();
    idle();
    repeat (3) gap_tick();

    // First run, recorded for comparison after a mid-pipe reset.
    recording = 1;
    repeat (3) one_pipe();
    recording = 0;

    // Freeze mid-pipe, then finish the pipe; also freeze during a gap.
    pipe_enter();
    idle();
    repeat (10) freeze();
    pipe_repeat();
    idle();
    pipe_exit();
    repeat (3) freeze();
    idle();
    repeat (3) gap_tick();

    // Reset mid-pipe with a tick present; reset must win.
    pipe_enter();
    idle();
    step(1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 8'd0, 0);
    idle();
    idle();
    repeat (3) gap_tick();
    replaying  = 1;
    replay_idx = 0;
    repeat (3) one_pipe();
    replaying  = 0;

    // Long run: opening shrink schedule and pipe_count saturation.
    repeat (260) one_pipe();

    begin : drain
      int budget;
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
        @(negedge Clock);
        budget--;
      end
      if (sb.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb.size());
      end
    end
    @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
